// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, status bit positions and sequencer state shared by the
// ALU sharing controller and its arbiter.
package alu_pkg;

  // ALU opcodes
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_DIV = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_LW  = 4'b1000;
  localparam logic [3:0] OP_LH  = 4'b1001;
  localparam logic [3:0] OP_SLL = 4'b1010;
  localparam logic [3:0] OP_SRL = 4'b1011;
  localparam logic [3:0] OP_NOR = 4'b1100;

  // alu_status bit positions
  localparam int STAT_ZERO     = 7;
  localparam int STAT_OVF      = 6;
  localparam int STAT_CARRY    = 5;
  localparam int STAT_NEG      = 4;
  localparam int STAT_INV_ADDR = 3;
  localparam int STAT_DIV0     = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // A response is erroneous when the result is not meaningful.
  function automatic logic status_err(input logic [7:0] s);
    return s[STAT_OVF] | s[STAT_INV_ADDR] | s[STAT_DIV0];
  endfunction

endpackage

// File: rtl/alu_share_arb.sv
// alu_share_arb: grant logic for the shared ALU.
// ALU_SHARE_RR_EN defined  : round-robin search starting at a pointer register.
// ALU_SHARE_RR_EN undefined: fixed priority, lowest index wins, no state.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
`ifdef ALU_SHARE_RR_EN
  input  logic               clk,
  input  logic               rst_n,
`endif
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx
);

  logic found;

`ifdef ALU_SHARE_RR_EN
  logic [ID_W-1:0] ptr_q, ptr_d;
  int              best_d;
  int              dist;

  // Pick the valid requester closest to the pointer, going upward with wrap.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    best_d  = NUM_REQ;
    dist    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      dist = i - int'(ptr_q);
      if (dist < 0) dist = dist + NUM_REQ;
      if (req_valid[i] && (dist < best_d)) begin
        best_d  = dist;
        gnt_idx = ID_W'(i);
      end
    end
    found = (best_d < NUM_REQ);
    for (int i = 0; i < NUM_REQ; i++)
      gnt[i] = en && found && (gnt_idx == ID_W'(i));
  end

  // Pointer moves just past the winner whenever a grant is issued.
  always_comb begin
    ptr_d = ptr_q;
    if (en && found)
      ptr_d = (int'(gnt_idx) + 1 >= NUM_REQ) ? '0 : gnt_idx + 1'b1;
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`else
  // Lowest-index valid requester wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i]) begin
        found   = 1'b1;
        gnt[i]  = en;
        gnt_idx = ID_W'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one combinational ALU between NUM_REQ requesters.
// One transaction in flight: IDLE accepts and registers operands, EXEC lets
// the ALU settle and captures its outputs, RESP holds the tagged response
// until the consumer takes it. Optional round-robin arbitration via
// ALU_SHARE_RR_EN (fixed priority when undefined).
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [4*NUM_REQ-1:0]    req_control,
  input  logic [32*NUM_REQ-1:0]   req_op1,
  input  logic [32*NUM_REQ-1:0]   req_op2,
  output logic [3:0]              alu_control,
  output logic [31:0]             alu_operand_1,
  output logic [31:0]             alu_operand_2,
  input  logic [31:0]             alu_result,
  input  logic [7:0]              alu_status,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [31:0]             rsp_result,
  output logic [7:0]              rsp_status,
  output logic                    rsp_err,
  output logic                    busy
);

  state_e          state_q, state_d;
  logic            accept, capture;
  logic            arb_en;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0] gnt_idx;

  logic [3:0]      sel_ctl;
  logic [31:0]     sel_op1, sel_op2;

  logic [3:0]      ctl_q, ctl_d;
  logic [31:0]     op1_q, op1_d;
  logic [31:0]     op2_q, op2_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [31:0]     res_q, res_d;
  logic [7:0]      stat_q, stat_d;

  // Grants are only meaningful while nothing is in flight.
  assign arb_en = (state_q == S_IDLE);

  alu_share_arb #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
`ifdef ALU_SHARE_RR_EN
    .clk       (clk),
    .rst_n     (rst_n),
`endif
    .req_valid (req_valid),
    .en        (arb_en),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx)
  );

  // Route the winner's payload toward the ALU input registers.
  always_comb begin
    sel_ctl = '0;
    sel_op1 = '0;
    sel_op2 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_ctl = req_control[4*i +: 4];
        sel_op1 = req_op1[32*i +: 32];
        sel_op2 = req_op2[32*i +: 32];
      end
    end
  end

  // Sequencer next state and datapath strobes.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      S_IDLE: if (|gnt) begin
        accept  = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        capture = 1'b1;
        state_d = S_RESP;
      end
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ALU inputs keep their last value between transactions; response fields
  // are captured once and held through RESP.
  always_comb begin
    ctl_d  = ctl_q;
    op1_d  = op1_q;
    op2_d  = op2_q;
    id_d   = id_q;
    res_d  = res_q;
    stat_d = stat_q;
    if (accept) begin
      ctl_d = sel_ctl;
      op1_d = sel_op1;
      op2_d = sel_op2;
      id_d  = gnt_idx;
    end
    if (capture) begin
      res_d  = alu_result;
      stat_d = alu_status;
    end
  end

  // State and datapath registers; reset drops any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ctl_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      id_q    <= '0;
      res_q   <= '0;
      stat_q  <= '0;
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      id_q    <= id_d;
      res_q   <= res_d;
      stat_q  <= stat_d;
    end
  end

  assign req_ready     = gnt;
  assign alu_control   = ctl_q;
  assign alu_operand_1 = op1_q;
  assign alu_operand_2 = op2_q;
  assign rsp_valid     = (state_q == S_RESP);
  assign rsp_id        = id_q;
  assign rsp_result    = res_q;
  assign rsp_status    = stat_q;
  assign rsp_err       = status_err(stat_q);
  assign busy          = (state_q != S_IDLE);

endmodule
